// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-add unsigned multiplier: one add-and-shift per RUN cycle,
// WIDTH iterations per product, followed by a one-cycle DONE pulse.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           state_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mreg_q, mreg_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;

    // The carry out of the upper-half add becomes the new top bit after the shift.
    assign addend = p_q[0] ? mreg_q : '0;
    assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mreg_q  <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mreg_q  <= mreg_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mreg_d  = mreg_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    p_d     = {{WIDTH{1'b0}}, multiplier};
                    mreg_d  = multiplicand;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake: start is only looked at in IDLE; done is a one-cycle pulse
    // marking product final, and product then holds until the next accepted start.
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = p_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed bench for shift_add_mult_ctrl: reset behaviour, latency, corner
// products, ignored starts, mid-run abort and back-to-back streaming.
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    shift_add_mult_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (a),
        .multiplier   (b),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, follow it to done and check latency, busy span and result.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [63:0] exp);
        int lat;
        int busy_cnt;
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        tick();
        start = 1'b0;
        a     = ~op_a;
        b     = op_b ^ 32'h5A5A_A5A5;
        check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        check({tag, "_idle_state"}, 64'(state_o), 64'd0);
        tick();
        check({tag, "_hold"}, product, exp);
    endtask

    initial begin : stim
        int lat;
        int done_cnt;
        logic [63:0] exp;

        // Reset with start high: must be ignored.
        reset = 1'b1;
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd5;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);
        check("rst_state", 64'(state_o), 64'd0);
        reset = 1'b0;

        run_op("a3_b5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("a_zero", 32'd0, 32'h1234_5678, 64'd0);
        run_op("b_zero", 32'h1234_5678, 32'd0, 64'd0);
        run_op("mixed", 32'hDEAD_BEEF, 32'h0000_1000, 64'h0000_0DEA_DBEE_F000);

        // Idle with start low and wandering operands: product holds.
        a = 32'd99;
        b = 32'd77;
        repeat (4) tick();
        check("idle_hold", product, 64'h0000_0DEA_DBEE_F000);
        check("idle_state", 64'(state_o), 64'd0);

        // Start during RUN is ignored.
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd9;
        tick();
        lat = 0;
        repeat (10) begin tick(); lat++; end
        a = 32'd2;
        b = 32'd2;
        repeat (5) begin tick(); lat++; end
        start = 1'b0;
        check("ign_still_busy", 64'(busy), 64'd1);
        while (!done && lat < 60) begin tick(); lat++; end
        check("ign_latency", 64'(lat), 64'd32);
        check("ign_product", product, 64'd63);
        tick();
        tick();
        check("ign_no_restart", 64'(state_o), 64'd0);
        check("ign_hold", product, 64'd63);

        // Asynchronous reset in the middle of RUN.
        start = 1'b1;
        a     = 32'h0000_FFFF;
        b     = 32'h0000_FFFF;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("abort_async_busy", 64'(busy), 64'd0);
        check("abort_async_product", product, 64'd0);
        check("abort_async_state", 64'(state_o), 64'd0);
        tick();
        reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_product_zero", product, 64'd0);
        run_op("after_abort", 32'd6, 32'd7, 64'd42);

        // Start held high: one result every 34 cycles.
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        exp_q.push_back({32'd0, a} * {32'd0, b});
        tick();
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < 100; i++) begin
            lat = (i == 0) ? 0 : 2;
            while (!done && lat < 60) begin tick(); lat++; end
            check("stream_period", 64'(lat), (i == 0) ? 64'd32 : 64'd34);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
            check("stream_product", product, exp);
            if (i < 99) begin
                a = $urandom;
                b = $urandom;
                exp_q.push_back({32'd0, a} * {32'd0, b});
            end else begin
                start = 1'b0;
            end
            tick();
            tick();
            if (i < 99) begin
                check("stream_accept", 64'(busy), 64'd1);
                a = $urandom;
                b = $urandom;
            end
        end
        check("stream_final_idle", 64'(state_o), 64'd0);
        check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
